// File: rtl/cgra_pkg.sv
// cgra_pkg: shared CGRA shell types (word width and word type) used by the buffers and uut_interface
package cgra_pkg;
    localparam int CGRA_DATA_W = 512;
    typedef logic [CGRA_DATA_W-1:0] cgra_word_t;
endpackage

// File: rtl/cgra_out_buffer_mem.sv
// cgra_out_buffer_mem: simple dual-port RAM, one write port, one read port with registered read
//   clk/rst  : clock, asynchronous active-low reset (clears only the read register)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port; rdata updates on the edge where re=1, holds otherwise
module cgra_out_buffer_mem #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/cgra_out_buffer.sv
// cgra_out_buffer: first-word-fall-through output FIFO between uut_interface and the host stream
//   clk, rst (async active-low)
//   valid_in/din        : write side from uut_interface; enable_out is registered backpressure
//   valid_out/ready_in/dout : host stream, dout held stable while valid_out & !ready_in
//   overflow            : sticky, a write arrived while full and was dropped
//   words_out           : delivered word count, present only with CGRA_OUT_BUF_STATS_EN defined
module cgra_out_buffer
    import cgra_pkg::*;
#(
    parameter int DATA_W = CGRA_DATA_W,
    parameter int DEPTH  = 16,
    parameter int SLACK  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] din,
    output logic              enable_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic [DATA_W-1:0] dout,
    output logic              overflow
`ifdef CGRA_OUT_BUF_STATS_EN
    ,
    output logic [31:0]       words_out
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, ram_count;
    logic          pop, load, push, full;

    // The mem read register doubles as the output register; count covers RAM plus that word.
    assign full      = count == (AW+1)'(DEPTH);
    assign pop       = valid_out & ready_in;
    assign ram_count = count - {{AW{1'b0}}, valid_out};
    assign load      = (ram_count != '0) & (~valid_out | pop);
    // A pop frees a slot in the same cycle, so a write while full is still accepted.
    assign push      = valid_in & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_out  <= 1'b0;
            overflow   <= 1'b0;
            enable_out <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr + {{(AW-1){1'b0}}, push};
            rd_ptr     <= rd_ptr + {{(AW-1){1'b0}}, load};
            count      <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            valid_out  <= load | (valid_out & ~pop);
            overflow   <= overflow | (valid_in & ~push);
            enable_out <= count < (AW+1)'(DEPTH - SLACK);
        end
    end

`ifdef CGRA_OUT_BUF_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) words_out <= '0;
        else if (pop) words_out <= words_out + 32'd1;
    end
`endif

    cgra_out_buffer_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (load),
        .raddr (rd_ptr),
        .rdata (dout)
    );
endmodule
